// File: rtl/fxp_pkg.sv
// Shared definitions for the sequential fixed-point multiplier and divider.
// Holds the default Q2.8 format, the FSM states and the counter-width helper.
package fxp_pkg;

  localparam int FXP_WIDTH = 10;
  localparam int FXP_FRAC  = 8;
  localparam int FXP_CNT_W = $clog2(FXP_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fxp_state_e;

  // The iteration counter must hold 0..w-1; keep it at least one bit wide.
  function automatic int fxp_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fxp_mul_datapath.sv
// Shift-add datapath: accumulator/multiplier shift register, the adder,
// and the round/saturate stage that produces the registered result.
module fxp_mul_datapath
  import fxp_pkg::*;
#(
  parameter int WIDTH = FXP_WIDTH,
  parameter int FRAC  = FXP_FRAC,
  parameter int ROUND = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p,
  output logic             ovf
);

  localparam int RW = 2*WIDTH - FRAC + 1;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_nx;
  logic               rnd;
  logic [RW-1:0]      r;
  logic               ovf_nx;
  logic [WIDTH-1:0]   p_nx;
  logic               unused_bits;

  // Adding into the upper half keeps the carry, then the whole word shifts right.
  assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_nx = {sum, acc[WIDTH-1:1]};

  generate
    if (ROUND != 0 && FRAC > 0) begin : g_round
      assign rnd = acc_nx[FRAC-1];
    end else begin : g_trunc
      assign rnd = 1'b0;
    end
  endgenerate

  // Round before the range check so a round-up can itself saturate.
  assign r      = {1'b0, acc_nx[2*WIDTH-1:FRAC]} + RW'(rnd);
  assign ovf_nx = |r[RW-1:WIDTH];
  assign p_nx   = ovf_nx ? '1 : r[WIDTH-1:0];

  assign unused_bits = ^{acc, acc_nx};

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      p      <= '0;
      ovf    <= 1'b0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      p      <= '0;
      ovf    <= 1'b0;
    end else if (step) begin
      acc    <= acc_nx;
      mplier <= mplier >> 1;
      if (last) begin
        p   <= p_nx;
        ovf <= ovf_nx;
      end
    end
  end

endmodule

// File: rtl/fxp_multiplier.sv
// Sequential unsigned fixed-point multiplier, one shift-add step per clock.
// Top level owns the IDLE/CALC/DONE FSM and the iteration counter.
module fxp_multiplier
  import fxp_pkg::*;
#(
  parameter int WIDTH = FXP_WIDTH,
  parameter int FRAC  = FXP_FRAC,
  parameter int ROUND = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] P,
  output logic             busy,
  output logic             ovf,
  output logic             valid
);

  localparam int CW = fxp_cnt_w(WIDTH);

  fxp_state_e    state, state_nx;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          step;
  logic          last;

  assign accept = start && (state != CALC);
  assign step   = (state == CALC);
  assign last   = step && (cnt == CW'(WIDTH-1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC:    if (last)   state_nx = DONE;
      DONE:    if (accept) state_nx = CALC;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == CALC);
    valid = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset)       cnt <= '0;
    else if (accept) cnt <= '0;
    else if (step)   cnt <= cnt + 1'b1;
  end

  fxp_mul_datapath #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ROUND (ROUND)
  ) u_dp (
    .clock (clock),
    .reset (reset),
    .load  (accept),
    .step  (step),
    .last  (last),
    .a     (A),
    .b     (B),
    .p     (P),
    .ovf   (ovf)
  );

endmodule

// File: tb/tb_fxp_multiplier.sv
// Directed bench for fxp_multiplier: a truncating and a rounding instance
// share the same stimulus and are checked against hand-computed Q2.8 products.
module tb_fxp_multiplier;

  localparam int W = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] P, P_r;
  logic         busy, ovf, valid;
  logic         busy_r, ovf_r, valid_r;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  fxp_multiplier #(.WIDTH(W), .FRAC(8), .ROUND(0)) dut (
    .clock (clock), .reset (reset), .start (start), .A (A), .B (B),
    .P (P), .busy (busy), .ovf (ovf), .valid (valid)
  );

  fxp_multiplier #(.WIDTH(W), .FRAC(8), .ROUND(1)) dut_r (
    .clock (clock), .reset (reset), .start (start), .A (A), .B (B),
    .P (P_r), .busy (busy_r), .ovf (ovf_r), .valid (valid_r)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse start for one edge, then count cycles until valid (bounded).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int nbusy, output logic v0);
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    v0 = valid;
    lat = 0; nbusy = 0;
    while (!valid && lat < 40) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({busy, valid, ovf, P} !== {1'b0, 1'b0, 1'b0, 10'h000}) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got busy=%b valid=%b ovf=%b P=%h, expected 0/0/0/000",
                 i, busy, valid, ovf, P);
      end
      tick();
    end
  endtask

  task automatic test_basic();
    int lat, nb; logic v0;
    run_op(10'h0A0, 10'h0B0, lat, nb, v0);
    n_chk++;
    if (lat !== 10 || nb !== 10) begin
      n_fail++; $display("FAIL basic_latency: got lat=%0d busy=%0d, expected 10/10", lat, nb);
    end
    n_chk++;
    if (P !== 10'h06E || ovf !== 1'b0) begin
      n_fail++; $display("FAIL basic_result: got P=%h ovf=%b, expected 06E/0", P, ovf);
    end
    for (int i = 0; i < 4; i++) tick();
    n_chk++;
    if (valid !== 1'b1 || P !== 10'h06E || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold: got valid=%b P=%h busy=%b, expected 1/06E/0", valid, P, busy);
    end
  endtask

  task automatic test_vectors();
    int lat, nb; logic v0;
    logic [W-1:0] va [3] = '{10'h0B0, 10'h000, 10'h3FF};
    logic [W-1:0] vb [3] = '{10'h070, 10'h3FF, 10'h001};
    logic [W-1:0] vp [3] = '{10'h04D, 10'h000, 10'h003};
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], lat, nb, v0);
      n_chk++;
      if (P !== vp[i] || ovf !== 1'b0 || lat !== 10) begin
        n_fail++;
        $display("FAIL vector[%0d]: got P=%h ovf=%b lat=%0d, expected %h/0/10", i, P, ovf, lat, vp[i]);
      end
    end
  endtask

  task automatic test_ovf();
    int lat, nb; logic v0;
    run_op(10'h300, 10'h200, lat, nb, v0);
    n_chk++;
    if (P !== 10'h3FF || ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_3x2: got P=%h ovf=%b, expected 3FF/1", P, ovf);
    end
    run_op(10'h3FF, 10'h3FF, lat, nb, v0);
    n_chk++;
    if (P !== 10'h3FF || ovf !== 1'b1 || P_r !== 10'h3FF || ovf_r !== 1'b1) begin
      n_fail++; $display("FAIL ovf_max: got P=%h ovf=%b P_r=%h ovf_r=%b, expected 3FF/1 both", P, ovf, P_r, ovf_r);
    end
  endtask

  task automatic test_round();
    int lat, nb; logic v0;
    run_op(10'h001, 10'h180, lat, nb, v0);
    n_chk++;
    if (P !== 10'h001 || P_r !== 10'h002 || ovf !== 1'b0 || ovf_r !== 1'b0) begin
      n_fail++; $display("FAIL round_half: got P=%h P_r=%h ovf=%b ovf_r=%b, expected 001/002/0/0", P, P_r, ovf, ovf_r);
    end
    // 0x170*0x2C8 = 0x3FF80: truncation just fits, rounding up saturates.
    run_op(10'h170, 10'h2C8, lat, nb, v0);
    n_chk++;
    if (P !== 10'h3FF || ovf !== 1'b0 || P_r !== 10'h3FF || ovf_r !== 1'b1) begin
      n_fail++; $display("FAIL round_ovf: got P=%h ovf=%b P_r=%h ovf_r=%b, expected 3FF/0/3FF/1", P, ovf, P_r, ovf_r);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    A = 10'h0A0; B = 10'h0B0; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!valid && lat < 40) begin
      if (lat == 3) begin
        start = 1'b1; A = 10'h3FF; B = 10'h3FF;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    n_chk++;
    if (lat !== 10 || P !== 10'h06E || ovf !== 1'b0) begin
      n_fail++; $display("FAIL ignore_start: got lat=%0d P=%h ovf=%b, expected 10/06E/0", lat, P, ovf);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nb; logic v0;
    run_op(10'h0B0, 10'h070, lat, nb, v0);
    run_op(10'h300, 10'h200, lat, nb, v0);
    n_chk++;
    if (v0 !== 1'b0 || lat !== 10 || P !== 10'h3FF || ovf !== 1'b1) begin
      n_fail++; $display("FAIL back_to_back: got v0=%b lat=%0d P=%h ovf=%b, expected 0/10/3FF/1", v0, lat, P, ovf);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nb; logic v0;
    A = 10'h0A0; B = 10'h0B0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++;
    if ({busy, valid, ovf, P} !== {1'b0, 1'b0, 1'b0, 10'h000}) begin
      n_fail++; $display("FAIL reset_mid: got busy=%b valid=%b ovf=%b P=%h, expected 0/0/0/000", busy, valid, ovf, P);
    end
    tick();
    n_chk++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_idle: got busy=%b valid=%b, expected 0/0", busy, valid);
    end
    run_op(10'h0B0, 10'h070, lat, nb, v0);
    n_chk++;
    if (lat !== 10 || P !== 10'h04D || ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_fresh: got lat=%0d P=%h ovf=%b, expected 10/04D/0", lat, P, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_ovf();
    test_round();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
